axi_cmd_arbiter: RTL and testbench
==================================

Name: axi_cmd_arbiter

Overview:
- Shares the single AXI master command port between the write-side and read-side address controllers (one {valid, addr, length} requester each).
- Round-robin arbitration, gated by burst-level occupancy of the DDR ring buffer:
  - writes only when a slot is free;
  - reads only when a completed write burst is available.
- Sits between wr/rd address controllers and the AXI master; issues one registered command at a time.

Parameters:
P_AXI_ADDR_WIDTH, 32, address width of requester and command buses
P_DEPTH_BURSTS, 16, ring-buffer capacity in bursts (integer ≥2)
P_CNT_WIDTH, $clog2(P_DEPTH_BURSTS+1), occupancy counter width (derived, localparam)

Ports:
i_clk  input  1  clock
r_rst  input  1  reset, asynchronous, active-high
i_ddr_init  input  1  DDR calibration done, async to i_clk
i_wr_valid  input  1  write requester request, held until o_wr_ready
i_wr_addr  input  P_AXI_ADDR_WIDTH  write burst address
i_wr_length  input  8  write AXI len (beats-1)
o_wr_ready  output  1  one-cycle accept pulse to write requester
i_rd_valid  input  1  read requester request, held until o_rd_ready
i_rd_addr  input  P_AXI_ADDR_WIDTH  read burst address
i_rd_length  input  8  read AXI len
o_rd_ready  output  1  one-cycle accept pulse to read requester
o_cmd_valid  output  1  command valid to AXI master
o_cmd_we  output  1  1 = write command, 0 = read command
o_cmd_addr  output  P_AXI_ADDR_WIDTH  command address
o_cmd_length  output  8  command AXI len
i_cmd_ready  input  1  AXI master accepts command
i_wr_done  input  1  one-cycle pulse: write burst response (BRESP) received
o_fill  output  P_CNT_WIDTH  committed bursts available to read
o_full  output  1  reserved == P_DEPTH_BURSTS
o_empty  output  1  committed == 0
o_err  output  1  sticky: i_wr_done with no outstanding write

Behaviour:
- Reset (async on r_rst; mid-command as well): all outputs 0, counters 0, FSM IDLE, round-robin pointer = write-first. o_cmd_valid drops immediately; in-flight command is abandoned.
- i_ddr_init: two-flop synchroniser. While the synced value is 0, no grant occurs.
- Counters:
  - reserved: +1 on write-command handshake, −1 on read-command handshake.
  - committed: +1 on i_wr_done, −1 on read-command handshake.
  - Simultaneous +1 and −1 on one counter leaves it unchanged.
  - Invariant: committed ≤ reserved ≤ P_DEPTH_BURSTS.
- Eligibility:
  - wr_elig = i_wr_valid && reserved < P_DEPTH_BURSTS
  - rd_elig = i_rd_valid && committed > 0
- FSM:
  - IDLE:
    - Both eligible: grant the side pointed to by the RR pointer.
    - One eligible: grant it.
    - On grant: load o_cmd_addr/o_cmd_length/o_cmd_we from the granted requester; pulse that side's ready for exactly 1 cycle; o_cmd_valid <= 1; go to CMD. Grant-to-o_cmd_valid latency is 1 cycle.
  - CMD: hold o_cmd_valid and payload stable until i_cmd_ready. On handshake: o_cmd_valid <= 0, update counters, toggle RR pointer to the other side, go to GAP.
  - GAP: one idle cycle, then IDLE. A requester must deassert valid the cycle after its ready pulse, so it is never re-granted on stale valid.
  - Undefined state: go to IDLE.
- Throughput: at most one command per 3 cycles (IDLE → CMD → GAP) when i_cmd_ready is already high.
- i_wr_done while committed == reserved: ignored for counting; o_err set until reset.
- i_wr_done during reset: ignored.
- o_full/o_empty/o_fill are registered views of the counters, updated the same cycle as the counters.

Decomposition:
- Shared package axi_ctrl_pkg:
  - FSM state encoding (P_ST_IDLE=0, P_ST_CMD=1, P_ST_GAP=2);
  - AXI len width (8);
  - default address width.
- Sub-module axi_burst_occupancy: both counters, full/empty/err logic, eligibility outputs.
- The arbiter FSM and command register stay in the top level.

Test Plan:
1. i_ddr_init=0, i_wr_valid=1 for 20 cycles → no o_wr_ready, o_cmd_valid=0. Raise i_ddr_init → o_wr_ready within 4 cycles; o_cmd_we=1; o_cmd_addr=i_wr_addr; o_cmd_length=8'd255.
2. i_cmd_ready held 0 for 10 cycles after grant → o_cmd_valid and payload stable all 10 cycles. Ready=1 → valid low next cycle; reserved=1.
3. Write issued, no i_wr_done, i_rd_valid=1 → no read grant. Pulse i_wr_done → o_fill=1, o_empty=0, read granted with o_cmd_we=0; after handshake o_fill=0, o_empty=1.
4. Both requesters valid continuously with committed>0 → grants alternate W,R,W,R starting with write after reset.
5. P_DEPTH_BURSTS=16: 16 writes with no reads → o_full=1; 17th write request not granted. One read handshake → write granted next IDLE.
6. Pulse i_wr_done with reserved=0 → o_err=1, o_fill stays 0. Assert r_rst mid-CMD → o_cmd_valid=0 and o_err=0 immediately.

Source files
------------

// File: rtl/axi_cmd_arbiter_pkg.sv
// Shared definitions for the AXI command arbiter slice: FSM encoding,
// AXI length width and default address width.
package axi_ctrl_pkg;

  localparam int unsigned P_AXI_LEN_WIDTH      = 8;
  localparam int unsigned P_AXI_ADDR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    P_ST_IDLE = 2'd0,
    P_ST_CMD  = 2'd1,
    P_ST_GAP  = 2'd2
  } arb_state_e;

  // Width needed to count 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_cmd_arbiter_if.sv
// Requester / AXI-master / occupancy-status bundle for axi_cmd_arbiter.
// slave modport is the arbiter's view; master modport is the environment's view.
interface axi_cmd_arbiter_if
  import axi_ctrl_pkg::*;
#(
  parameter int unsigned P_AXI_ADDR_WIDTH = P_AXI_ADDR_WIDTH_DEF,
  parameter int unsigned P_DEPTH_BURSTS   = 16
);

  localparam int unsigned P_CNT_WIDTH = cnt_width(P_DEPTH_BURSTS);

  logic                        i_ddr_init;
  logic                        i_wr_valid;
  logic [P_AXI_ADDR_WIDTH-1:0] i_wr_addr;
  logic [P_AXI_LEN_WIDTH-1:0]  i_wr_length;
  logic                        o_wr_ready;
  logic                        i_rd_valid;
  logic [P_AXI_ADDR_WIDTH-1:0] i_rd_addr;
  logic [P_AXI_LEN_WIDTH-1:0]  i_rd_length;
  logic                        o_rd_ready;
  logic                        o_cmd_valid;
  logic                        o_cmd_we;
  logic [P_AXI_ADDR_WIDTH-1:0] o_cmd_addr;
  logic [P_AXI_LEN_WIDTH-1:0]  o_cmd_length;
  logic                        i_cmd_ready;
  logic                        i_wr_done;
  logic [P_CNT_WIDTH-1:0]      o_fill;
  logic                        o_full;
  logic                        o_empty;
  logic                        o_err;

  modport slave (
    input  i_ddr_init,
    input  i_wr_valid, i_wr_addr, i_wr_length,
    output o_wr_ready,
    input  i_rd_valid, i_rd_addr, i_rd_length,
    output o_rd_ready,
    output o_cmd_valid, o_cmd_we, o_cmd_addr, o_cmd_length,
    input  i_cmd_ready,
    input  i_wr_done,
    output o_fill, o_full, o_empty, o_err
  );

  modport master (
    output i_ddr_init,
    output i_wr_valid, i_wr_addr, i_wr_length,
    input  o_wr_ready,
    output i_rd_valid, i_rd_addr, i_rd_length,
    input  o_rd_ready,
    input  o_cmd_valid, o_cmd_we, o_cmd_addr, o_cmd_length,
    output i_cmd_ready,
    output i_wr_done,
    input  o_fill, o_full, o_empty, o_err
  );

endinterface

// File: rtl/axi_cmd_arbiter_occupancy.sv
// Burst-level occupancy of the DDR ring buffer: reserved (write commands
// issued, not yet read back) and committed (write responses received, not
// yet read back). Produces request eligibility and registered status.
module axi_burst_occupancy
  import axi_ctrl_pkg::*;
#(
  parameter int unsigned P_DEPTH_BURSTS = 16,
  parameter int unsigned P_CNT_WIDTH    = cnt_width(P_DEPTH_BURSTS)
) (
  input  logic                   i_clk,
  input  logic                   r_rst,
  input  logic                   i_wr_valid,
  input  logic                   i_rd_valid,
  input  logic                   i_wr_hs,
  input  logic                   i_rd_hs,
  input  logic                   i_wr_done,
  output logic                   o_wr_elig,
  output logic                   o_rd_elig,
  output logic [P_CNT_WIDTH-1:0] o_fill,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_err
);

  localparam logic [P_CNT_WIDTH-1:0] P_DEPTH_C = P_CNT_WIDTH'(P_DEPTH_BURSTS);
  localparam logic [P_CNT_WIDTH-1:0] P_ONE_C   = P_CNT_WIDTH'(1);

  logic [P_CNT_WIDTH-1:0] reserved_q, reserved_d;
  logic [P_CNT_WIDTH-1:0] committed_q, committed_d;
  logic [P_CNT_WIDTH-1:0] fill_q;
  logic                   full_q, empty_q, err_q, err_d;
  logic                   done_ok;
  logic                   done_bad;

  assign done_bad = i_wr_done && (committed_q == reserved_q);
  assign done_ok  = i_wr_done && (committed_q != reserved_q);

  assign o_wr_elig = i_wr_valid && (reserved_q < P_DEPTH_C);
  assign o_rd_elig = i_rd_valid && (committed_q != '0);

  // Next counter values; opposing +1/-1 in one cycle cancel out.
  always_comb begin
    reserved_d  = reserved_q;
    committed_d = committed_q;
    err_d       = err_q | done_bad;
    case ({i_wr_hs, i_rd_hs})
      2'b10:   reserved_d = reserved_q + P_ONE_C;
      2'b01:   reserved_d = reserved_q - P_ONE_C;
      default: reserved_d = reserved_q;
    endcase
    case ({done_ok, i_rd_hs})
      2'b10:   committed_d = committed_q + P_ONE_C;
      2'b01:   committed_d = committed_q - P_ONE_C;
      default: committed_d = committed_q;
    endcase
  end

  // Counters and their registered status views, updated on the same edge.
  always_ff @(posedge i_clk or posedge r_rst) begin
    if (r_rst) begin
      reserved_q  <= '0;
      committed_q <= '0;
      fill_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      reserved_q  <= reserved_d;
      committed_q <= committed_d;
      fill_q      <= committed_d;
      full_q      <= (reserved_d == P_DEPTH_C);
      empty_q     <= (committed_d == '0);
      err_q       <= err_d;
    end
  end

  assign o_fill  = fill_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_err   = err_q;

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI command port between the write-side
// and read-side address controllers, gated by ring-buffer occupancy.
// One registered command in flight at a time: IDLE -> CMD -> GAP.
module axi_cmd_arbiter
  import axi_ctrl_pkg::*;
#(
  parameter int unsigned P_AXI_ADDR_WIDTH = P_AXI_ADDR_WIDTH_DEF,
  parameter int unsigned P_DEPTH_BURSTS   = 16
) (
  input  logic              i_clk,
  input  logic              r_rst,
  axi_cmd_arbiter_if.slave  bus
);

  localparam int unsigned P_CNT_WIDTH = cnt_width(P_DEPTH_BURSTS);

  arb_state_e                  state_q;
  logic                        rr_rd_q;
  logic                        cmd_valid_q;
  logic                        cmd_we_q;
  logic [P_AXI_ADDR_WIDTH-1:0] cmd_addr_q;
  logic [P_AXI_LEN_WIDTH-1:0]  cmd_len_q;
  logic                        wr_ready_q;
  logic                        rd_ready_q;
  logic                        init_meta_q, init_sync_q;

  logic                        wr_elig, rd_elig;
  logic                        grant_wr_d, grant_rd_d;
  logic                        cmd_hs;

  assign cmd_hs = cmd_valid_q && bus.i_cmd_ready;

  // Two-flop synchroniser for the asynchronous calibration-done flag.
  always_ff @(posedge i_clk or posedge r_rst) begin
    if (r_rst) begin
      init_meta_q <= 1'b0;
      init_sync_q <= 1'b0;
    end else begin
      init_meta_q <= bus.i_ddr_init;
      init_sync_q <= init_meta_q;
    end
  end

  axi_burst_occupancy #(
    .P_DEPTH_BURSTS (P_DEPTH_BURSTS),
    .P_CNT_WIDTH    (P_CNT_WIDTH)
  ) u_occ (
    .i_clk      (i_clk),
    .r_rst      (r_rst),
    .i_wr_valid (bus.i_wr_valid),
    .i_rd_valid (bus.i_rd_valid),
    .i_wr_hs    (cmd_hs && cmd_we_q),
    .i_rd_hs    (cmd_hs && !cmd_we_q),
    .i_wr_done  (bus.i_wr_done),
    .o_wr_elig  (wr_elig),
    .o_rd_elig  (rd_elig),
    .o_fill     (bus.o_fill),
    .o_full     (bus.o_full),
    .o_empty    (bus.o_empty),
    .o_err      (bus.o_err)
  );

  // Grant decision in IDLE: RR pointer breaks ties, a lone eligible side wins.
  always_comb begin
    grant_wr_d = 1'b0;
    grant_rd_d = 1'b0;
    if (state_q == P_ST_IDLE && init_sync_q) begin
      if (wr_elig && rd_elig) begin
        grant_rd_d = rr_rd_q;
        grant_wr_d = !rr_rd_q;
      end else begin
        grant_wr_d = wr_elig;
        grant_rd_d = rd_elig;
      end
    end
  end

  // Arbiter FSM with registered command payload and ready pulses.
  always_ff @(posedge i_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q     <= P_ST_IDLE;
      rr_rd_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      wr_ready_q  <= 1'b0;
      rd_ready_q  <= 1'b0;
    end else begin
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
      case (state_q)
        P_ST_IDLE: begin
          if (grant_wr_d || grant_rd_d) begin
            cmd_valid_q <= 1'b1;
            cmd_we_q    <= grant_wr_d;
            cmd_addr_q  <= grant_wr_d ? bus.i_wr_addr : bus.i_rd_addr;
            cmd_len_q   <= grant_wr_d ? bus.i_wr_length : bus.i_rd_length;
            wr_ready_q  <= grant_wr_d;
            rd_ready_q  <= grant_rd_d;
            state_q     <= P_ST_CMD;
          end
        end
        P_ST_CMD: begin
          if (bus.i_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            rr_rd_q     <= cmd_we_q;
            state_q     <= P_ST_GAP;
          end
        end
        P_ST_GAP: begin
          state_q <= P_ST_IDLE;
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= P_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_wr_ready   = wr_ready_q;
  assign bus.o_rd_ready   = rd_ready_q;
  assign bus.o_cmd_valid  = cmd_valid_q;
  assign bus.o_cmd_we     = cmd_we_q;
  assign bus.o_cmd_addr   = cmd_addr_q;
  assign bus.o_cmd_length = cmd_len_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Scoreboard bench for axi_cmd_arbiter: stimulus pushes expected commands,
// a monitor pops and compares on every command handshake.
module tb_axi_cmd_arbiter;
  import axi_ctrl_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_cmd_arbiter_if #(.P_AXI_ADDR_WIDTH(AW), .P_DEPTH_BURSTS(DEPTH)) bus();

  axi_cmd_arbiter #(.P_AXI_ADDR_WIDTH(AW), .P_DEPTH_BURSTS(DEPTH)) dut (
    .i_clk (clk),
    .r_rst (rst),
    .bus   (bus)
  );

  cmd_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic manual_done = 1'b0;
  logic auto_done   = 1'b0;
  logic auto_pend   = 1'b0;
  logic auto_en     = 1'b0;

  assign bus.i_wr_done = manual_done | auto_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted command must match the head of the scoreboard.
  always @(negedge clk) begin
    cmd_t a;
    cmd_t e;
    if (!rst && bus.o_cmd_valid && bus.i_cmd_ready) begin
      a = {bus.o_cmd_we, bus.o_cmd_addr, bus.o_cmd_length};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h expected none", a);
      end else begin
        e = exp_q.pop_front();
        check("sb_cmd", a, e);
      end
    end
  end

  // Write-response responder: one BRESP pulse a cycle after each write handshake.
  always @(negedge clk) begin
    auto_done = auto_pend;
    auto_pend = auto_en && !rst && bus.o_cmd_valid && bus.i_cmd_ready && bus.o_cmd_we;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wait_ready(input bit is_wr, input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (is_wr ? bus.o_wr_ready : bus.o_rd_ready) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue(input bit is_wr, input logic [AW-1:0] addr, input logic [7:0] len);
    bit got;
    @(posedge clk); #1;
    if (is_wr) begin
      bus.i_wr_valid = 1'b1; bus.i_wr_addr = addr; bus.i_wr_length = len;
    end else begin
      bus.i_rd_valid = 1'b1; bus.i_rd_addr = addr; bus.i_rd_length = len;
    end
    wait_ready(is_wr, 20, got);
    check(is_wr ? "wr_grant" : "rd_grant", 64'(got), 64'd1);
    @(posedge clk); #1;
    if (is_wr) bus.i_wr_valid = 1'b0;
    else       bus.i_rd_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 manual_done = 1'b1;
    @(posedge clk); #1 manual_done = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit   got;
    bit   seen;
    bit   stable;
    logic [AW-1:0] a1;
    logic [AW-1:0] r1;
    logic [AW-1:0] w17;

    bus.i_ddr_init  = 1'b0;
    bus.i_wr_valid  = 1'b0;
    bus.i_wr_addr   = '0;
    bus.i_wr_length = '0;
    bus.i_rd_valid  = 1'b0;
    bus.i_rd_addr   = '0;
    bus.i_rd_length = '0;
    bus.i_cmd_ready = 1'b0;
    a1  = 32'h1000_0000;
    r1  = 32'h2000_0040;
    w17 = 32'h5001_0000;

    // Reset state: every output low while r_rst is held.
    repeat (3) @(negedge clk);
    check("reset_outs",
          {bus.o_cmd_valid, bus.o_cmd_we, bus.o_wr_ready, bus.o_rd_ready,
           bus.o_full, bus.o_empty, bus.o_err, 27'(bus.o_fill), bus.o_cmd_addr != '0, bus.o_cmd_length != '0},
          64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: no grant before calibration, then a grant within 4 cycles.
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = a1; bus.i_wr_length = 8'd255;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= bus.o_wr_ready | bus.o_cmd_valid;
    end
    check("no_grant_before_init", 64'(seen), 64'd0);
    check("empty_after_reset", 64'(bus.o_empty), 64'd1);
    exp_q.push_back({1'b1, a1, 8'd255});
    bus.i_ddr_init = 1'b1;
    wait_ready(1'b1, 4, got);
    check("init_grant", 64'(got), 64'd1);
    check("grant_payload", {bus.o_cmd_valid, bus.o_cmd_we, bus.o_cmd_addr, bus.o_cmd_length},
          {1'b1, 1'b1, a1, 8'd255});
    @(posedge clk); #1 bus.i_wr_valid = 1'b0;

    // 2: command held stable while the master stalls.
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.o_cmd_valid && bus.o_cmd_we && bus.o_cmd_addr == a1 &&
            bus.o_cmd_length == 8'd255 && !bus.o_wr_ready)) stable = 1'b0;
    end
    check("cmd_hold", 64'(stable), 64'd1);
    @(posedge clk); #1 bus.i_cmd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("valid_drop", 64'(bus.o_cmd_valid), 64'd0);
    check("status_after_write", {bus.o_full, 32'(bus.o_fill)}, 64'd0);

    // 3: read blocked until the write response arrives.
    bus.i_rd_valid = 1'b1; bus.i_rd_addr = r1; bus.i_rd_length = 8'd7;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= bus.o_rd_ready | bus.o_cmd_valid;
    end
    check("no_read_uncommitted", 64'(seen), 64'd0);
    exp_q.push_back({1'b0, r1, 8'd7});
    pulse_done();
    @(negedge clk);
    check("fill_after_done", {32'(bus.o_fill), 1'b0, bus.o_empty}, {32'd1, 2'b00});
    wait_ready(1'b0, 6, got);
    check("read_grant", 64'(got), 64'd1);
    @(posedge clk); #1 bus.i_rd_valid = 1'b0;
    @(negedge clk);
    check("fill_after_read", {32'(bus.o_fill), 1'b0, bus.o_empty}, {32'd0, 2'b01});
    check("no_err", 64'(bus.o_err), 64'd0);

    // 4: both requesters continuously valid -> W,R,W,R,W,R.
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 32'h3000_0000 + 32'(i * 32'h100), 8'd15});
      exp_q.push_back({1'b0, 32'h4000_0000 + 32'(i * 32'h100), 8'd31});
    end
    fork
      for (int i = 0; i < 3; i++) issue(1'b1, 32'h3000_0000 + 32'(i * 32'h100), 8'd15);
      for (int j = 0; j < 3; j++) issue(1'b0, 32'h4000_0000 + 32'(j * 32'h100), 8'd31);
    join
    repeat (4) @(negedge clk);
    auto_en = 1'b0;
    check("alternate_drained", 64'(exp_q.size()), 64'd0);
    check("alternate_status", {32'(bus.o_fill), 1'b0, bus.o_empty}, {32'd0, 2'b01});

    // 5: fill the ring, block the 17th write, free one slot by a read.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b1, 32'h5000_0000 + 32'(i * 32'h1000), 8'd63});
      issue(1'b1, 32'h5000_0000 + 32'(i * 32'h1000), 8'd63);
    end
    repeat (3) @(negedge clk);
    check("full_after_16", {bus.o_full, 32'(bus.o_fill)}, {1'b1, 32'd0});
    @(posedge clk); #1;
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = w17; bus.i_wr_length = 8'd1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= bus.o_wr_ready | bus.o_cmd_valid;
    end
    check("no_write_when_full", 64'(seen), 64'd0);
    exp_q.push_back({1'b0, 32'h6000_0000, 8'd3});
    exp_q.push_back({1'b1, w17, 8'd1});
    pulse_done();
    issue(1'b0, 32'h6000_0000, 8'd3);
    wait_ready(1'b1, 10, got);
    check("write_after_free", 64'(got), 64'd1);
    @(posedge clk); #1 bus.i_wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("full_again", {bus.o_full, 32'(bus.o_fill), bus.o_empty}, {1'b1, 32'd0, 1'b1});

    // 6: spurious write response, then asynchronous reset mid-command.
    do_reset();
    repeat (3) @(posedge clk);
    pulse_done();
    @(negedge clk);
    check("err_spurious", {bus.o_err, 32'(bus.o_fill)}, {1'b1, 32'd0});
    bus.i_cmd_ready = 1'b0;
    @(posedge clk); #1;
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 32'h7000_0000; bus.i_wr_length = 8'd0;
    wait_ready(1'b1, 6, got);
    check("grant_before_reset", {63'(got), bus.o_cmd_valid}, {63'd1, 1'b1});
    @(posedge clk); #1 bus.i_wr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_reset", {bus.o_cmd_valid, bus.o_err, bus.o_cmd_we}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
